// File: rtl/forward_hazard_unit.sv
// forward_hazard_unit
//   EX-stage operand forwarding and load-use hazard detection for a
//   pipelined LEGv8-style core with NPORTS source-operand ports.
//   The unit keeps its own shadow copy of the destination/control fields
//   of the instructions sitting in ID/EX, EX/MEM and MEM/WB. From these it
//   picks the freshest value for each ALU operand and requests a single
//   bubble whenever the instruction in ID consumes a load that is in EX.
//
// Ports
//   clk          core clock
//   reset        synchronous, active-high reset
//   en           pipeline advance; 0 holds every shadow stage and counter
//   flush        taken branch in MEM; squashes ID/EX and EX/MEM shadows
//   id_rs        ID-stage source indices, port p at [p*REGW +: REGW]
//   id_rs_used   per-port "operand is read" flags for the ID instruction
//   id_rd        ID-stage destination register
//   id_regWrite  ID-stage instruction writes id_rd
//   id_memRead   ID-stage instruction is a load
//   ex_rdata     register-file operands held in ID/EX, port p at [p*N +: N]
//   exR          EX/MEM ALU result
//   wbR          MEM/WB writeback value
//   ex_Y         forwarded ALU operands, port p at [p*N +: N]
//   ex_sel       per-port select: 00 reg, 01 exR, 10 wbR
//   stall        hold PC and IF/ID; a bubble enters ID/EX
//   stall_cnt    cycles with stall=1 and en=1 (wraps)
//   fwd_cnt      advancing cycles where any port forwards (wraps)

module forward_hazard_unit #(
  parameter int N        = 64,
  parameter int NPORTS   = 2,
  parameter int REGW     = 5,
  parameter int ZERO_REG = 31,
  parameter int CNTW     = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   flush,
  input  logic [NPORTS*REGW-1:0] id_rs,
  input  logic [NPORTS-1:0]      id_rs_used,
  input  logic [REGW-1:0]        id_rd,
  input  logic                   id_regWrite,
  input  logic                   id_memRead,
  input  logic [NPORTS*N-1:0]    ex_rdata,
  input  logic [N-1:0]           exR,
  input  logic [N-1:0]           wbR,
  output logic [NPORTS*N-1:0]    ex_Y,
  output logic [2*NPORTS-1:0]    ex_sel,
  output logic                   stall,
  output logic [CNTW-1:0]        stall_cnt,
  output logic [CNTW-1:0]        fwd_cnt
);

  localparam logic [REGW-1:0] ZR      = REGW'(ZERO_REG);
  localparam logic [1:0]      SEL_REG = 2'b00;
  localparam logic [1:0]      SEL_EXR = 2'b01;
  localparam logic [1:0]      SEL_WBR = 2'b10;

  // ID/EX shadow
  logic                   idex_v;
  logic [NPORTS*REGW-1:0] idex_rs;
  logic [NPORTS-1:0]      idex_used;
  logic [REGW-1:0]        idex_rd;
  logic                   idex_reg_write;
  logic                   idex_mem_read;

  // EX/MEM shadow
  logic                   exmem_v;
  logic [REGW-1:0]        exmem_rd;
  logic                   exmem_reg_write;
  logic                   exmem_mem_read;

  // MEM/WB shadow
  logic                   memwb_v;
  logic [REGW-1:0]        memwb_rd;
  logic                   memwb_reg_write;

  logic                   load_in_ex;
  logic                   exmem_fwd_ok;
  logic                   memwb_fwd_ok;
  logic [NPORTS-1:0]      use_hit;
  logic [NPORTS-1:0]      port_fwd;
  logic                   any_fwd;

  // A load in EX with a real destination is the only producer that cannot
  // be satisfied by forwarding next cycle.
  assign load_in_ex   = idex_v && idex_mem_read && (idex_rd != ZR);

  // Loads in EX/MEM have no data yet on exR, so they never qualify here.
  assign exmem_fwd_ok = exmem_v && exmem_reg_write && !exmem_mem_read && (exmem_rd != ZR);
  assign memwb_fwd_ok = memwb_v && memwb_reg_write && (memwb_rd != ZR);

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    logic [REGW-1:0] rs;
    logic            ex_live;
    logic            hit_ex;
    logic            hit_wb;
    logic [1:0]      sel;

    assign rs      = idex_rs[p*REGW +: REGW];
    assign ex_live = idex_v && idex_used[p];

    // EX/MEM is checked first: it holds the youngest producer.
    assign hit_ex  = ex_live && exmem_fwd_ok && (exmem_rd == rs);
    assign hit_wb  = ex_live && memwb_fwd_ok && (memwb_rd == rs);

    assign sel     = hit_ex ? SEL_EXR :
                     hit_wb ? SEL_WBR : SEL_REG;

    assign ex_sel[2*p +: 2] = sel;
    assign ex_Y[p*N +: N]   = hit_ex ? exR :
                              hit_wb ? wbR : ex_rdata[p*N +: N];
    assign port_fwd[p]      = (sel != SEL_REG);

    assign use_hit[p] = load_in_ex && id_rs_used[p] &&
                        (id_rs[p*REGW +: REGW] == idex_rd);

    // The single load-use bubble guarantees a consumer never sits in EX
    // while its load is in EX/MEM; seeing it means the stall path broke.
    always_ff @(posedge clk) begin
      if (!reset) begin
        assert (!(ex_live && exmem_v && exmem_reg_write && exmem_mem_read &&
                  (exmem_rd != ZR) && (exmem_rd == rs)))
          else $error("load in EX/MEM feeds port %0d of the EX instruction", p);
      end
    end
  end

  assign stall   = |use_hit;
  assign any_fwd = |port_fwd;

  always_ff @(posedge clk) begin
    if (reset) begin
      idex_v          <= 1'b0;
      idex_rs         <= '0;
      idex_used       <= '0;
      idex_rd         <= '0;
      idex_reg_write  <= 1'b0;
      idex_mem_read   <= 1'b0;
      exmem_v         <= 1'b0;
      exmem_rd        <= '0;
      exmem_reg_write <= 1'b0;
      exmem_mem_read  <= 1'b0;
      memwb_v         <= 1'b0;
      memwb_rd        <= '0;
      memwb_reg_write <= 1'b0;
      stall_cnt       <= '0;
      fwd_cnt         <= '0;
    end else if (en) begin
      // MEM/WB always advances, even under flush: the branch in MEM itself
      // retires normally.
      memwb_v         <= exmem_v;
      memwb_rd        <= exmem_rd;
      memwb_reg_write <= exmem_reg_write;

      if (flush) begin
        idex_v  <= 1'b0;
        exmem_v <= 1'b0;
      end else begin
        exmem_v         <= idex_v;
        exmem_rd        <= idex_rd;
        exmem_reg_write <= idex_reg_write;
        exmem_mem_read  <= idex_mem_read;

        // On stall the ID instruction is presented again next cycle, so
        // only a bubble is recorded now.
        idex_v          <= !stall;
        idex_rs         <= id_rs;
        idex_used       <= id_rs_used;
        idex_rd         <= id_rd;
        idex_reg_write  <= id_regWrite;
        idex_mem_read   <= id_memRead;
      end

      if (stall) begin
        stall_cnt <= stall_cnt + CNTW'(1);
      end
      if (any_fwd) begin
        fwd_cnt <= fwd_cnt + CNTW'(1);
      end
    end
  end

endmodule
